// File: rtl/ensavg_pkg.sv
// Shared types and width helper for the streaming per-bin ensemble averager.
package ensavg_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    FLUSH,
    DRAIN
  } state_e;

  typedef enum logic {
    MODE_BLOCK = 1'b0,
    MODE_EXP   = 1'b1
  } mode_e;

  // Accumulator width: sample width plus headroom for 2^log2_m summed frames.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2_m);
    return w + log2_m;
  endfunction

endpackage

// File: rtl/ensavg_update.sv
// Combinational per-bin accumulator update for block-mean and exponential averaging.
module ensavg_update
  import ensavg_pkg::*;
#(
  parameter int unsigned W      = 24,
  parameter int unsigned LOG2_M = 4,
  parameter int unsigned AW     = acc_width(W, LOG2_M)
) (
  input  logic signed [AW-1:0] acc,
  input  logic signed [W-1:0]  x,
  input  mode_e                mode,
  input  logic                 first,
  output logic signed [AW-1:0] acc_next
);

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] decay;

  assign x_ext = {{LOG2_M{x[W-1]}}, x};
  assign decay = acc >>> LOG2_M;

  always_comb begin
    acc_next = acc;
    unique case (mode)
      MODE_BLOCK: acc_next = first ? x_ext : acc + x_ext;
      // Bounded by x * 2^LOG2_M in steady state, so AW bits never wrap.
      MODE_EXP:   acc_next = acc + x_ext - decay;
      default:    acc_next = acc;
    endcase
  end

endmodule

// File: rtl/ensemble_averager_v2.sv
// Streaming per-bin ensemble averager with BRAM accumulators, block or exponential mode.
// Define ENSAVG_ROUND_EN for round-half-up, saturated output; default is floor truncation.
module ensemble_averager_v2
  import ensavg_pkg::*;
#(
  parameter int unsigned W      = 24,
  parameter int unsigned WF     = 12,
  parameter int unsigned N_BINS = 1024,
  parameter int unsigned LOG2_M = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                mode_i,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [LOG2_M-1:0]   ens_cnt
);

  localparam int unsigned AW = acc_width(W, LOG2_M);
  localparam int unsigned BW = $clog2(N_BINS);
  localparam logic [BW-1:0] LastBin = BW'(N_BINS - 1);

  if (WF >= W) begin : g_wf_chk
    $error("WF must be smaller than W");
  end
  if ((N_BINS < 4) || ((N_BINS & (N_BINS - 1)) != 0)) begin : g_bins_chk
    $error("N_BINS must be a power of 2 and at least 4");
  end
  if ((LOG2_M < 1) || (LOG2_M > 8)) begin : g_m_chk
    $error("LOG2_M must be in 1..8");
  end

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [LOG2_M-1:0]    ens_q, ens_d;
  logic                 flush_q, flush_d;
  logic                 issued_q, issued_d;
  logic                 ov_q, ov_d;
  logic                 ol_q, ol_d;

  logic                 s0_valid_q;
  logic [BW-1:0]        s0_addr_q;
  logic signed [W-1:0]  s0_data_q;
  logic                 s0_first_q;

  logic signed [AW-1:0] mem [N_BINS];
  logic signed [AW-1:0] rd_q;
  logic signed [AW-1:0] acc_next;
  logic                 hs, rd_en, drain_issue, out_pop;
  logic                 we;
  logic [BW-1:0]        waddr;
  logic signed [AW-1:0] wdata;

  assign in_ready    = (state_q == ACCUM);
  assign hs          = in_valid && in_ready;
  assign out_pop     = ov_q && out_ready;
  assign drain_issue = (state_q == DRAIN) && !issued_q && (!ov_q || out_ready);
  assign rd_en       = hs || drain_issue;
  assign out_valid   = ov_q;
  assign out_last    = ol_q;
  assign ens_cnt     = ens_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    ens_d    = ens_q;
    flush_d  = flush_q;
    issued_d = issued_q;
    ov_d     = ov_q;
    ol_d     = ol_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBin) state_d = ACCUM;
      end
      ACCUM: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBin) begin
            ens_d = ens_q + 1'b1;
            if (&ens_q) begin
              state_d = FLUSH;
              flush_d = 1'b0;
            end
          end
        end
      end
      FLUSH: begin
        // Two idle cycles let the final RMW write land before the first drain read.
        flush_d = 1'b1;
        if (flush_q) begin
          state_d  = DRAIN;
          issued_d = 1'b0;
        end
      end
      DRAIN: begin
        if (out_pop) begin
          ov_d = 1'b0;
          ol_d = 1'b0;
        end
        if (drain_issue) begin
          ov_d  = 1'b1;
          ol_d  = (cnt_q == LastBin);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBin) issued_d = 1'b1;
        end
        if (out_pop && ol_q) begin
          if ((mode_q == MODE_EXP) && (mode_e'(mode_i) == mode_q)) begin
            state_d = ACCUM;
          end else begin
            state_d = CLEAR;
            mode_d  = mode_e'(mode_i);
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= CLEAR;
      mode_q     <= mode_e'(mode_i);
      cnt_q      <= '0;
      ens_q      <= '0;
      flush_q    <= 1'b0;
      issued_q   <= 1'b0;
      ov_q       <= 1'b0;
      ol_q       <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_addr_q  <= '0;
      s0_data_q  <= '0;
      s0_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      ens_q      <= ens_d;
      flush_q    <= flush_d;
      issued_q   <= issued_d;
      ov_q       <= ov_d;
      ol_q       <= ol_d;
      s0_valid_q <= hs;
      if (hs) begin
        s0_addr_q  <= cnt_q;
        s0_data_q  <= in_data;
        s0_first_q <= (ens_q == '0);
      end
    end
  end

  ensavg_update #(
    .W      (W),
    .LOG2_M (LOG2_M),
    .AW     (AW)
  ) u_update (
    .acc      (rd_q),
    .x        (s0_data_q),
    .mode     (mode_q),
    .first    (s0_first_q),
    .acc_next (acc_next)
  );

  always_comb begin
    we    = s0_valid_q;
    waddr = s0_addr_q;
    wdata = acc_next;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdata = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the RMW operand and the output holding register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[cnt_q];
    end
  end

`ifdef ENSAVG_ROUND_EN
  localparam logic signed [AW:0] RoundC = (AW+1)'(1) <<< (LOG2_M - 1);
  logic signed [AW:0] rd_ext;
  logic signed [W:0]  rnd_top;

  assign rd_ext  = $signed({rd_q[AW-1], rd_q});
  assign rnd_top = (W+1)'((rd_ext + RoundC) >>> LOG2_M);

  always_comb begin
    out_data = rnd_top[W-1:0];
    if (rnd_top[W] != rnd_top[W-1]) begin
      out_data = rnd_top[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign out_data = W'(rd_q >>> LOG2_M);
`endif

endmodule

// File: tb/tb_ensemble_averager_v2.sv
// Scoreboard bench for ensemble_averager_v2: reference model pushes expected frames, monitor pops.
module tb_ensemble_averager_v2;

  localparam int unsigned W  = 24;
  localparam int unsigned WF = 12;
  localparam int unsigned N  = 8;
  localparam int unsigned L  = 2;
  localparam int unsigned M  = 1 << L;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                mode_i;
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [L-1:0]        ens_cnt;

  ensemble_averager_v2 #(
    .W      (W),
    .WF     (WF),
    .N_BINS (N),
    .LOG2_M (L)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .mode_i    (mode_i),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ens_cnt   (ens_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  longint        cyc = 0;
  int            ready_pct = 100;
  longint        m_acc [N];
  int            m_bin, m_cnt;
  logic          m_mode;
  bit            expect_rise;
  longint        rise_cyc;
  logic          prev_v, prev_r;
  logic [W+1:0]  prev_word;
  logic signed [W-1:0] rnd_vals [8*N];

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint scale(input longint a);
`ifdef ENSAVG_ROUND_EN
    longint r  = (a + (64'sd1 <<< (L - 1))) >>> L;
    longint mx = (64'sd1 <<< (W - 1)) - 1;
    if (r > mx) r = mx;
    if (r < -mx - 1) r = -mx - 1;
    return r;
`else
    return a >>> L;
`endif
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Reference model and output monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    longint x;
    exp_t   e;
    if (!Rst) begin
      sb.delete();
      for (int b = 0; b < N; b++) m_acc[b] = 0;
      m_bin = 0;
      m_cnt = 0;
      m_mode = mode_i;
      expect_rise = 0;
      prev_v = 1'b0;
      prev_r = 1'b1;
    end else begin
      if (prev_v && !prev_r) begin
        check_eq("stall_hold", longint'({out_valid, out_last, out_data}), longint'(prev_word));
      end
      if (out_valid && !prev_v && expect_rise) begin
        check_eq("out_latency", cyc, rise_cyc);
        expect_rise = 0;
      end
      if (out_valid) check_eq("in_ready_in_drain", longint'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("out_data", longint'(out_data), e.data);
          check_eq("out_last", longint'(out_last), longint'(e.last));
          if (e.last && ((m_mode == 1'b0) || (mode_i != m_mode))) begin
            for (int b = 0; b < N; b++) m_acc[b] = 0;
            m_mode = mode_i;
          end
        end
      end
      if (in_valid && in_ready) begin
        check_eq("ens_cnt", longint'(ens_cnt), m_cnt);
        x = longint'(in_data);
        if (m_mode) m_acc[m_bin] = m_acc[m_bin] + x - (m_acc[m_bin] >>> L);
        else m_acc[m_bin] = m_acc[m_bin] + x;
        m_bin++;
        if (m_bin == N) begin
          m_bin = 0;
          m_cnt++;
          if (m_cnt == M) begin
            m_cnt = 0;
            for (int b = 0; b < N; b++) begin
              e.data = scale(m_acc[b]);
              e.last = (b == N - 1);
              sb.push_back(e);
            end
            expect_rise = 1;
            rise_cyc = cyc + 4;
          end
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_word = {out_valid, out_last, out_data};
    end
  end

  task automatic do_reset();
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_out_last", longint'(out_last), 0);
    check_eq("rst_out_data", longint'(out_data), 0);
    check_eq("rst_in_ready", longint'(in_ready), 0);
    check_eq("rst_ens_cnt", longint'(ens_cnt), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (N - 1) @(posedge Clk);
    #1;
    check_eq("clear_len_lo", longint'(in_ready), 0);
    @(posedge Clk);
    #1;
    check_eq("clear_len_hi", longint'(in_ready), 1);
  endtask

  task automatic send_sample(input longint v, input int gap_pct);
    int n = 0;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = v[W-1:0];
    forever begin
      @(negedge Clk);
      if (in_ready || n >= 2000) break;
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", longint'(in_ready), 1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((sb.size() != 0 || out_valid) && n < 5000);
    check_eq("drain_done", sb.size(), 0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b0;
    mode_i = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    @(posedge Clk);
    #1;
    do_reset();

    // Block mean of a ramp: expect 0,4,...,28.
    for (int f = 0; f < M; f++)
      for (int b = 0; b < N; b++) send_sample(b * 4, 0);
    wait_idle();

    // Random data, with input gaps and output stalls, then replayed gap-free.
    for (int i = 0; i < 8 * N; i++) rnd_vals[i] = W'($urandom);
    ready_pct = 30;
    for (int i = 0; i < 8 * N; i++) send_sample(longint'(rnd_vals[i]), 40);
    wait_idle();
    ready_pct = 100;
    for (int i = 0; i < 8 * N; i++) send_sample(longint'(rnd_vals[i]), 0);
    wait_idle();

    // Rounding case (sum 5) and saturation extremes.
    for (int f = 0; f < M; f++)
      for (int b = 0; b < N; b++) send_sample((f == M - 1) ? 2 : 1, 0);
    wait_idle();
    for (int f = 0; f < M; f++)
      for (int b = 0; b < N; b++) send_sample((b < N / 2) ? 24'sh7FFFFF : -24'sh800000, 0);
    wait_idle();

    // Reset while bin 3 of a drain is presented; next frame must be fresh.
    for (int f = 0; f < M; f++)
      for (int b = 0; b < N; b++) send_sample(b + 100, 0);
    begin
      int n = 0;
      do begin
        @(negedge Clk);
        n++;
      end while (!out_valid && n < 200);
      check_eq("drain_start", longint'(out_valid), 1);
    end
    repeat (3) @(posedge Clk);
    #1;
    do_reset();
    for (int f = 0; f < M; f++)
      for (int b = 0; b < N; b++) send_sample(b * 3 - 5, 0);
    wait_idle();

    // Exponential mode: one zero frame then a step to 400.
    mode_i = 1'b1;
    do_reset();
    for (int b = 0; b < N; b++) send_sample(0, 0);
    for (int f = 0; f < 3 * M - 1; f++)
      for (int b = 0; b < N; b++) send_sample(400, 0);
    wait_idle();

    // Flip to block mode mid-accumulation: this output stays exponential.
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < N; b++) send_sample(400, 0);
    mode_i = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < N; b++) send_sample(400, 0);
    wait_idle();
    for (int f = 0; f < M; f++)
      for (int b = 0; b < N; b++) send_sample(b * 4 + f, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
